// File: rtl/instr_encode_loader_pkg.sv
// Shared definitions for the instruction loader: instruction classes,
// MIPS primary opcodes (same values the control unit decodes) and field positions.
package instr_encode_loader_pkg;

    typedef enum logic [3:0] {
        CLS_RTYPE = 4'd0,
        CLS_ADDI  = 4'd1,
        CLS_ORI   = 4'd2,
        CLS_LUI   = 4'd3,
        CLS_BEQ   = 4'd4,
        CLS_BNE   = 4'd5,
        CLS_ANDI  = 4'd6,
        CLS_LW    = 4'd7,
        CLS_SW    = 4'd8,
        CLS_J     = 4'd9,
        CLS_JAL   = 4'd10
    } instrClass_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_ERROR
    } loadState_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jType(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: instruction class plus decoded fields -> 32-bit MIPS word.
// Classes outside the supported set raise illegal and yield a zero word.
module mips_instr_encode
    import instr_encode_loader_pkg::*;
(
    input  logic [3:0]  instrClass,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the instruction format by class; unused fields are simply ignored
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (instrClass)
            CLS_RTYPE: begin
                word[OP_LSB    +: 6] = OP_RTYPE;
                word[RS_LSB    +: 5] = rs;
                word[RT_LSB    +: 5] = rt;
                word[RD_LSB    +: 5] = rd;
                word[SHAMT_LSB +: 5] = shamt;
                word[FUNCT_LSB +: 6] = funct;
            end
            CLS_ADDI: word = iType(OP_ADDI, rs, rt, imm);
            CLS_ORI:  word = iType(OP_ORI,  rs, rt, imm);
            CLS_LUI:  word = iType(OP_LUI,  rs, rt, imm);
            CLS_BEQ:  word = iType(OP_BEQ,  rs, rt, imm);
            CLS_BNE:  word = iType(OP_BNE,  rs, rt, imm);
            CLS_ANDI: word = iType(OP_ANDI, rs, rt, imm);
            CLS_LW:   word = iType(OP_LW,   rs, rt, imm);
            CLS_SW:   word = iType(OP_SW,   rs, rt, imm);
            CLS_J:    word = jType(OP_J,   target);
            CLS_JAL:  word = jType(OP_JAL, target);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts decoded field bundles over valid/ready, encodes each
// into a MIPS word and writes it to consecutive instruction-memory addresses.
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_class,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + DEPTH - 1);

    loadState_e            state, nextState;
    logic [31:0]           encWord;
    logic                  encIllegal;
    logic                  accept;
    logic                  legalAccept;
    logic                  startSession;
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH:0]   wordCount;
    logic                  vld_p1;
    logic [31:0]           word_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic                  done_p1;
    logic                  errFlag;

    mips_instr_encode u_encode (
        .instrClass (in_class),
        .rs         (in_rs),
        .rt         (in_rt),
        .rd         (in_rd),
        .shamt      (in_shamt),
        .funct      (in_funct),
        .imm        (in_imm),
        .target     (in_target),
        .word       (encWord),
        .illegal    (encIllegal)
    );

    assign in_ready     = (state == ST_LOAD);
    assign busy         = (state == ST_LOAD) || (state == ST_FLUSH);
    assign accept       = in_valid && in_ready;
    assign legalAccept  = accept && !encIllegal;
    // start only opens a session from IDLE or ERROR; inside LOAD an accept always wins
    assign startSession = start && ((state == ST_IDLE) || (state == ST_ERROR));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: illegal class beats last, last beats address overflow
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  if (start) nextState = ST_LOAD;
            ST_LOAD: begin
                if (accept) begin
                    if (encIllegal)              nextState = ST_ERROR;
                    else if (in_last)            nextState = ST_FLUSH;
                    else if (wrPtr == LAST_ADDR) nextState = ST_ERROR;
                end
            end
            ST_FLUSH: nextState = ST_IDLE;
            ST_ERROR: if (start) nextState = ST_LOAD;
            default:  nextState = ST_IDLE;
        endcase
    end

    // Session control: write pointer, word count, done pulse and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr     <= FIRST_ADDR;
            wordCount <= '0;
            done_p1   <= 1'b0;
            errFlag   <= 1'b0;
        end else begin
            done_p1 <= (state == ST_FLUSH);
            if (startSession) begin
                wrPtr     <= FIRST_ADDR;
                wordCount <= '0;
                errFlag   <= 1'b0;
            end else begin
                if (legalAccept) begin
                    wrPtr     <= wrPtr + ADDR_WIDTH'(1);
                    wordCount <= wordCount + (ADDR_WIDTH + 1)'(1);
                end
                if ((state == ST_LOAD) && (nextState == ST_ERROR)) errFlag <= 1'b1;
            end
        end
    end

    // p0 -> p1: accepted word is registered and presented to memory one cycle later;
    // between writes the address output rests on the next free address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            word_p1 <= '0;
            addr_p1 <= FIRST_ADDR;
        end else begin
            vld_p1  <= legalAccept;
            addr_p1 <= startSession ? FIRST_ADDR : wrPtr;
            if (legalAccept) word_p1 <= encWord;
        end
    end

    assign mem_we    = vld_p1;
    assign mem_wdata = word_p1;
    assign mem_addr  = addr_p1;
    assign done      = done_p1;
    assign error     = errFlag;
    assign count     = wordCount;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Randomized self-checking bench for instr_encode_loader with a behavioural model.
module tb_instr_encode_loader;

    localparam int AW    = 8;
    localparam int BASE  = 0;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_class = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]    in_funct = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, done, error;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .error(error), .count(count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from opcode numbers and field weights
    function automatic logic [31:0] refEncode(input int cls, input int rs, input int rt, input int rd,
                                              input int sh, input int fn, input int imm, input int tgt);
        int opTab [11];
        longint w;
        opTab = '{0, 8, 13, 15, 4, 5, 12, 35, 43, 2, 3};
        if (cls == 0)
            w = longint'(rs) * (2**21) + longint'(rt) * (2**16) + longint'(rd) * (2**11) + sh * 64 + fn;
        else if (cls == 9 || cls == 10)
            w = longint'(opTab[cls]) * (64'd1 << 26) + tgt;
        else
            w = longint'(opTab[cls]) * (64'd1 << 26) + longint'(rs) * (2**21) + longint'(rt) * (2**16) + imm;
        return w[31:0];
    endfunction

    // Behavioural model: what the loader must show after each clock edge
    bit            mAcc = 0, mFlush = 0, mErr = 0, mDone = 0, mWe = 0, mTook = 0;
    bit            wasAcc, wasFlush;
    logic [31:0]   mData = '0;
    logic [AW-1:0] mNext = AW'(BASE), mAddr = AW'(BASE);
    int            mCount = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mAcc = 0; mFlush = 0; mErr = 0; mDone = 0; mWe = 0; mTook = 0;
            mNext = AW'(BASE); mAddr = AW'(BASE); mCount = 0;
        end else begin
            wasAcc = mAcc; wasFlush = mFlush;
            mDone = wasFlush; mFlush = 0; mWe = 0; mTook = 0;
            mAddr = mNext;
            if (wasAcc && in_valid) begin
                mTook = 1;
                if (in_class > 10) begin
                    mAcc = 0; mErr = 1;
                end else begin
                    mWe = 1;
                    mData = refEncode(in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
                    mCount++;
                    if (in_last) begin
                        mAcc = 0; mFlush = 1;
                    end else if (int'(mNext) == BASE + DEPTH - 1) begin
                        mAcc = 0; mErr = 1;
                    end
                    mNext = mNext + 1'b1;
                end
            end else if (!wasAcc && !wasFlush && start) begin
                mAcc = 1; mErr = 0; mCount = 0; mNext = AW'(BASE); mAddr = AW'(BASE);
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            check("mem_we", mem_we, mWe);
            if (mWe) check("mem_wdata", mem_wdata, mData);
            check("mem_addr", mem_addr, mAddr);
            check("done", done, mDone);
            check("error", error, mErr);
            check("busy", busy, mAcc | mFlush);
            check("in_ready", in_ready, mAcc);
            check("count", count, mCount);
        end
    end

    task automatic drv();
        @(negedge clk); #1;
    endtask

    task automatic setBundle(input int cls, input int rs, input int rt, input int rd, input int sh,
                             input int fn, input int imm, input int tgt, input bit last);
        in_class = 4'(cls); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
        in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
    endtask

    task automatic randBundle(input bit allowIllegal);
        int cls;
        cls = (allowIllegal && $urandom_range(0, 11) == 0) ? int'($urandom_range(11, 15))
                                                            : int'($urandom_range(0, 10));
        setBundle(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                  $urandom_range(0, 26'h3FFFFFF), $urandom_range(0, 2) == 0);
    endtask

    task automatic startSession();
        drv(); start = 1'b1;
        drv(); start = 1'b0;
    endtask

    // Offer the held bundle with throttled valid (and stray start pulses) until taken
    task automatic sendBundle();
        bit took = 0;
        for (int i = 0; i < 50; i++) begin
            drv();
            in_valid = ($urandom_range(0, 3) != 0);
            start    = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            if (mTook) begin took = 1; break; end
        end
        drv(); in_valid = 1'b0; start = 1'b0;
        if (!took) check("bundle_accept_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy_done_error", {busy, done, error}, 3'b000);
        check("rst_count", count, 0);
        drv(); reset = 1'b0;

        // Pin the model's encoder
        check("model_addi", refEncode(1, 0, 8, 0, 0, 0, 5, 0), 32'h20080005);
        check("model_rtype", refEncode(0, 8, 9, 10, 0, 32, 0, 0), 32'h01095020);
        check("model_lw", refEncode(7, 8, 9, 0, 0, 0, 4, 0), 32'h8D090004);
        check("model_lui", refEncode(3, 0, 1, 0, 0, 0, 32'h1001, 0), 32'h3C011001);
        check("model_j", refEncode(9, 0, 0, 0, 0, 0, 0, 32'h0100000), 32'h08100000);
        check("model_jal", refEncode(10, 0, 0, 0, 0, 0, 0, 32'h0100000), 32'h0C100000);

        // ADDI then last: word at addr 0, done two cycles after accept
        startSession();
        setBundle(1, 0, 8, 0, 0, 0, 5, 0, 1'b1); in_valid = 1'b1;
        @(posedge clk); #1;
        check("addi_we", mem_we, 1);
        check("addi_word", mem_wdata, 32'h20080005);
        check("addi_addr", mem_addr, 0);
        check("addi_flush_ready", in_ready, 0);
        drv(); in_valid = 1'b0;
        @(posedge clk); #1;
        check("addi_done", done, 1);
        @(posedge clk); #1;
        check("addi_done_pulse", done, 0);

        // Back-to-back RTYPE then LW
        startSession();
        setBundle(0, 8, 9, 10, 0, 32'h20, 0, 0, 1'b0); in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_rtype_word", mem_wdata, 32'h01095020);
        check("b2b_rtype_addr", mem_addr, 0);
        drv(); setBundle(7, 8, 9, 0, 0, 0, 4, 0, 1'b1);
        @(posedge clk); #1;
        check("b2b_lw_we", mem_we, 1);
        check("b2b_lw_word", mem_wdata, 32'h8D090004);
        check("b2b_lw_addr", mem_addr, 1);
        drv(); in_valid = 1'b0;
        repeat (3) drv();

        // LUI, J, JAL through the model
        startSession();
        setBundle(3, 0, 1, 0, 0, 0, 32'h1001, 0, 1'b0); sendBundle();
        setBundle(9, 0, 0, 0, 0, 0, 0, 32'h0100000, 1'b0); sendBundle();
        setBundle(10, 0, 0, 0, 0, 0, 0, 32'h0100000, 1'b1); sendBundle();
        repeat (3) drv();

        // Illegal class, then start clears the error
        startSession();
        setBundle(12, 1, 2, 3, 4, 5, 6, 7, 1'b0); in_valid = 1'b1;
        @(posedge clk); #1;
        check("illegal_we", mem_we, 0);
        check("illegal_error", error, 1);
        check("illegal_ready", in_ready, 0);
        drv(); in_valid = 1'b0;
        startSession();
        check("restart_error", error, 0);
        check("restart_addr", mem_addr, BASE);

        // Overflow: four writes fill memory, the fifth bundle is refused
        for (int i = 0; i < 4; i++) begin
            setBundle(1, 0, i, 0, 0, 0, i, 0, 1'b0);
            sendBundle();
        end
        repeat (2) drv();
        check("ovf_error", error, 1);
        check("ovf_count", count, 4);
        setBundle(1, 0, 5, 0, 0, 0, 5, 0, 1'b0); in_valid = 1'b1;
        repeat (3) drv();
        in_valid = 1'b0;
        check("ovf_count_hold", count, 4);

        // Reset while a write is on the port
        startSession();
        setBundle(2, 3, 4, 0, 0, 0, 16'hBEEF, 0, 1'b0); in_valid = 1'b1;
        @(posedge clk); #1;
        check("midrst_we_before", mem_we, 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_wdata", mem_wdata, 0);
        check("midrst_addr", mem_addr, BASE);
        check("midrst_ctrl", {in_ready, busy, done, error}, 4'b0000);
        check("midrst_count", count, 0);
        drv(); in_valid = 1'b0; reset = 1'b0;

        // Random sessions with throttled valid and occasional illegal bundles
        for (int s = 0; s < 40; s++) begin
            startSession();
            for (int b = 0; b < 8; b++) begin
                if (!mAcc) break;
                randBundle(1'b1);
                sendBundle();
            end
            if (mErr) begin
                randBundle(1'b0); in_valid = 1'b1;
                repeat (2) drv();
                in_valid = 1'b0;
            end
            repeat ($urandom_range(2, 4)) drv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
